// File: rtl/hex_display_driver_pkg.sv
// hex_display_driver_pkg
// Shared definitions for the hex display driver: FSM state encoding,
// active-low seven-segment constants (bit0=a .. bit6=g) and the default
// hold time between display updates.
package hex_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SHOW = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Digit table, entry n is the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // 20 Hz at 50 MHz
    localparam int REFRESH_CYCLES_DEF = 2500000;

endpackage

// File: rtl/hex_display_driver_seg7_encode.sv
// seg7_encode
// Combinational BCD nibble to active-low seven-segment pattern.
//   digit : 4-bit BCD value; anything above 9 shows 'E'
//   blank : 1 forces all segments dark
//   seg   : pattern, bit0=a .. bit6=g, active-low
module seg7_encode
    import hex_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            if (digit > 4'd9) seg = SEG_E;
            else              seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/hex_display_driver.sv
// hex_display_driver
// Captures five BCD digits plus a sign flag on a load handshake, scans the
// digits from most to least significant to suppress leading zeros, then
// updates six registered active-low HEX outputs at once and holds them for
// REFRESH_CYCLES before accepting the next value.
//   clk, reset         : clock (rising edge), async active-low reset
//   load / ready       : capture request; accepted when both high at an edge
//   d_one .. d_five    : BCD digits, units .. ten-thousands
//   sign_pos           : 1 = non-negative, 0 = show '-' on hex5
//   hex0 .. hex5       : segment outputs, hex0 = units, hex5 = sign
module hex_display_driver
    import hex_display_driver_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter bit BLANK_ZEROS    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d_one,
    input  logic [3:0] d_two,
    input  logic [3:0] d_three,
    input  logic [3:0] d_four,
    input  logic [3:0] d_five,
    input  logic       sign_pos,
    output logic       ready,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    // 0 and 1 both collapse to a single hold cycle.
    localparam int HOLD_N = (REFRESH_CYCLES > 1) ? REFRESH_CYCLES : 1;
    localparam int CNT_W  = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_N - 1);

    state_t            state, nxt;
    logic [5:1][3:0]   sh_dig;
    logic              sh_sign;
    logic              blank_q;
    logic [2:0]        idx;
    logic [3:0][6:0]   pat;      // scanned patterns, [3]=five .. [0]=two
    logic [CNT_W-1:0]  cnt;

    logic [3:0]        cur_dig;
    logic              enc_blank;
    logic [6:0]        enc_seg;

    always_comb begin
        case (idx)
            3'd5:    cur_dig = sh_dig[5];
            3'd4:    cur_dig = sh_dig[4];
            3'd3:    cur_dig = sh_dig[3];
            3'd2:    cur_dig = sh_dig[2];
            default: cur_dig = sh_dig[1];
        endcase
    end

    // Blanking only happens during SCAN; in SHOW the units digit is encoded
    // with blank forced low so a zero value still shows '0'.
    assign enc_blank = (state == ST_SCAN) && blank_q && (cur_dig == 4'd0);

    seg7_encode u_enc (
        .digit (cur_dig),
        .blank (enc_blank),
        .seg   (enc_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt   = state;
        ready = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (load) nxt = ST_SCAN;
            end
            ST_SCAN: if (idx == 3'd2) nxt = ST_SHOW;
            ST_SHOW: nxt = ST_HOLD;
            ST_HOLD: if (cnt == '0) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_dig  <= '0;
            sh_sign <= 1'b0;
            blank_q <= 1'b0;
            idx     <= '0;
            pat     <= '0;
            cnt     <= '0;
            hex0    <= SEG_BLANK;
            hex1    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex3    <= SEG_BLANK;
            hex4    <= SEG_BLANK;
            hex5    <= SEG_BLANK;
        end else begin
            case (state)
                ST_IDLE: if (load) begin
                    sh_dig  <= {d_five, d_four, d_three, d_two, d_one};
                    sh_sign <= sign_pos;
                    blank_q <= BLANK_ZEROS;
                    idx     <= 3'd5;
                end
                ST_SCAN: begin
                    // First non-blank digit ends suppression for good, so
                    // interior zeros stay lit.
                    pat <= {pat[2:0], enc_seg};
                    if (!enc_blank) blank_q <= 1'b0;
                    idx <= idx - 3'd1;
                end
                ST_SHOW: begin
                    hex4 <= pat[3];
                    hex3 <= pat[2];
                    hex2 <= pat[1];
                    hex1 <= pat[0];
                    hex0 <= enc_seg;
                    hex5 <= sh_sign ? SEG_BLANK : SEG_MINUS;
                    cnt  <= HOLD_LOAD;
                end
                ST_HOLD: if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       sign_pos = 1'b1;
    logic [3:0] d_one = '0, d_two = '0, d_three = '0, d_four = '0, d_five = '0;

    logic       ready_b, ready_n;
    logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
    logic [6:0] hn0, hn1, hn2, hn3, hn4, hn5;

    always #5 clk = ~clk;

    hex_display_driver #(.REFRESH_CYCLES(R), .BLANK_ZEROS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load(load),
        .d_one(d_one), .d_two(d_two), .d_three(d_three), .d_four(d_four), .d_five(d_five),
        .sign_pos(sign_pos), .ready(ready_b),
        .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5)
    );

    hex_display_driver #(.REFRESH_CYCLES(R), .BLANK_ZEROS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .load(load),
        .d_one(d_one), .d_two(d_two), .d_three(d_three), .d_four(d_four), .d_five(d_five),
        .sign_pos(sign_pos), .ready(ready_n),
        .hex0(hn0), .hex1(hn1), .hex2(hn2), .hex3(hn3), .hex4(hn4), .hex5(hn5)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] segv(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // dg = {five, four, three, two, one}; result = {hex5 .. hex0}
    function automatic logic [41:0] mdl(input logic [19:0] dg, input logic sp, input bit bz);
        logic [5:0][6:0] h;
        logic [3:0]      v;
        bit              lead;
        lead = bz;
        for (int i = 4; i >= 0; i--) begin
            v = dg[i*4 +: 4];
            if (lead && v == 4'd0 && i != 0) h[i] = 7'h7F;
            else begin
                lead = 1'b0;
                h[i] = segv(v);
            end
        end
        h[5] = sp ? 7'h7F : 7'b0111111;
        return h;
    endfunction

    // Reference timing: accepted load -> display at 5th edge, idle R edges later.
    int          busy = 0;
    logic [41:0] disp_b = {6{7'h7F}};
    logic [41:0] disp_n = {6{7'h7F}};
    logic [41:0] q_b[$];
    logic [41:0] q_n[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 0;
            disp_b <= {6{7'h7F}};
            disp_n <= {6{7'h7F}};
            q_b.delete();
            q_n.delete();
        end else if (busy == 0) begin
            if (load) begin
                q_b.push_back(mdl({d_five, d_four, d_three, d_two, d_one}, sign_pos, 1'b1));
                q_n.push_back(mdl({d_five, d_four, d_three, d_two, d_one}, sign_pos, 1'b0));
                busy <= R + 5;
            end
        end else begin
            busy <= busy - 1;
            if (busy == R + 1 && q_b.size() > 0 && q_n.size() > 0) begin
                disp_b <= q_b.pop_front();
                disp_n <= q_n.pop_front();
            end
        end
    end

    wire [41:0] ob = {hb5, hb4, hb3, hb2, hb1, hb0};
    wire [41:0] on = {hn5, hn4, hn3, hn2, hn1, hn0};

    always @(negedge clk) begin
        chk("ready_b", 64'(ready_b), 64'(busy == 0));
        chk("ready_n", 64'(ready_n), 64'(busy == 0));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("blank.hex%0d", i), 64'(ob[i*7 +: 7]), 64'(disp_b[i*7 +: 7]));
            chk($sformatf("noblank.hex%0d", i), 64'(on[i*7 +: 7]), 64'(disp_n[i*7 +: 7]));
        end
    end

    task automatic ld(input logic [19:0] dg, input logic sp, input int hold_cyc);
        @(negedge clk);
        {d_five, d_four, d_three, d_two, d_one} = dg;
        sign_pos = sp;
        load = 1'b1;
        repeat (hold_cyc) @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        ld(20'h00123, 1'b1, 1); repeat (12) @(negedge clk);
        ld(20'h32768, 1'b0, 1); repeat (12) @(negedge clk);
        ld(20'h01005, 1'b1, 1); repeat (12) @(negedge clk);
        ld(20'h00000, 1'b1, 1); repeat (12) @(negedge clk);
        ld(20'h00000, 1'b0, 1); repeat (12) @(negedge clk);
        ld(20'h00A00, 1'b1, 1); repeat (12) @(negedge clk);

        // new value pulsed while holding: must be dropped
        ld(20'h98765, 1'b1, 1); repeat (6) @(negedge clk);
        ld(20'h11111, 1'b0, 1); repeat (10) @(negedge clk);

        // load held high across ready rising: accepted twice
        ld(20'h00042, 1'b1, 12); repeat (15) @(negedge clk);

        // reset in the middle of a scan
        ld(20'h55555, 1'b0, 1);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_b), 64'd1);
        chk("rst_hex", 64'(ob), 64'({6{7'h7F}}));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);

        chk("queue_empty", 64'(q_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
